mdu: RTL
========

# mdu

Iterative, parametrised multiply/divide unit that extends the single-cycle ALU with the RV32M operations. Sits beside the ALU in the execute stage. Accepts one operation through a valid/ready handshake, computes one bit per cycle, and returns the result through a second valid/ready handshake. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Must be at least 4.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: request carries a valid op/a/b.
- `in_ready` output, 1 bit: the unit can accept a request. Equals `state==IDLE && !rst`.
- `op` input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a` input, WIDTH bits: first operand (rs1).
- `b` input, WIDTH bits: second operand (rs2).
- `out_valid` output, 1 bit: `result` is valid.
- `out_ready` input, 1 bit: the consumer takes the result.
- `result` output, WIDTH bits: the computed value.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- States:
  - IDLE: `in_ready=1`.
  - CALC: WIDTH iterations.
  - FIXUP: sign correction and special-case substitution.
  - DONE: `out_valid=1`.
- Accept occurs when `in_valid && in_ready`. At accept the unit latches op, records the operand signs, and converts signed operands to magnitudes.
  - Signed operands: MUL (either), MULH (both), MULHSU (a only), DIV/REM (both).
- CALC, multiply: shift-add, 2*WIDTH-bit product.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- CALC, divide: restoring shift-subtract, producing a quotient and a remainder.
- FIXUP:
  - Product sign is `sa^sb`. The full 2*WIDTH product is negated before the high/low select.
  - Quotient sign is `sa^sb`. Remainder sign is `sa`.
- Special cases are applied in FIXUP in every configuration:
  - b==0: DIV/DIVU give all ones. REM/REMU give a.
  - DIV with a = most negative and b = -1: result is a. REM for the same operands: result is 0.
- DONE holds `result` stable until `out_ready`, then goes to IDLE. There is no accept in the same cycle as result handoff.
- `in_valid` while busy is ignored. No request is queued.
- Reset at any point returns the unit to IDLE and clears `result`, `out_valid` and the iteration counter. An operation in flight is discarded.

## Timing
- Reset values: `result=0`, `out_valid=0`, `busy=0`. `in_ready=0` while `rst` is high and 1 on the first cycle after.
- Accept edge T0. CALC covers edges T0+1..T0+WIDTH. FIXUP is edge T0+WIDTH+1. `out_valid` rises after edge T0+WIDTH+1.
  - Full latency is WIDTH+1 cycles: 33 at WIDTH=32.
- Iteration counter: width is $clog2(WIDTH)+1. It counts from 0 to WIDTH-1 and does not wrap.
- `out_ready` may already be high when `out_valid` rises. The handoff then completes in that same cycle, and IDLE (`in_ready=1`) follows on the next cycle.
- The earliest back-to-back accept is one cycle after handoff.

## Configuration
- `MDU_FAST_SPECIAL_EN` defined:
  - Fast cases at accept: b==0 for a divide, the signed divide overflow case, or a==0 or b==0 for a multiply.
  - For these the unit skips CALC and goes straight to FIXUP. `out_valid` rises after edge T0+1 (latency 1).
- `MDU_FAST_SPECIAL_EN` undefined: every operation takes the full WIDTH+1 cycles.
- Results are bit-identical in both configurations.

## Structure
- `mdu_pkg`:
  - `mdu_op_e` (the 3-bit op enum).
  - `mdu_state_e` (IDLE, CALC, FIXUP, DONE).
  - Helper constant `OP_IS_DIV` = op[2].
- Sub-module `mdu_step`: combinational single iteration. Takes mode (mul/div), accumulator and operand, and returns the next accumulator and the next quotient/multiplier register.
- The top level holds the FSM, counter, sign flags and FIXUP mux.

## Test plan
- MUL a=7, b=-3 → `result`=0xFFFFFFEB. `out_valid` rises 33 cycles after accept.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=-7, b=2 → -3. REM a=-7, b=2 → -1. DIVU a=0xFFFFFFFF, b=16 → 0x0FFFFFFF. REMU same operands → 0xF.
- DIV a=5, b=0 → 0xFFFFFFFF. REM a=5, b=0 → 5. DIV a=0x80000000, b=-1 → 0x80000000. REM same operands → 0.
  - Latency is 1 with the macro and 33 without it; values are identical.
- Hold `out_ready`=0 for 10 cycles after `out_valid`:
  - `result` stays stable and `busy` stays 1.
  - A second `in_valid` in that window is not accepted.
- Assert `rst` at cycle 12 of a DIV → on the next cycle `out_valid`=0, `result`=0, `busy`=0, and `in_ready`=1 one cycle after `rst` drops.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types and decode helpers
// for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } mdu_state_e;

  localparam int OP_IS_DIV = 2;

  function automatic logic is_div(input mdu_op_e op);
    return op[OP_IS_DIV];
  endfunction

  function automatic logic sgn_a(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU,
                      OP_DIV, OP_REM};
  endfunction

  function automatic logic sgn_b(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration, either a
// shift-add multiply step or a restoring divide step.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mq_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
    rem  = {acc, mq[WIDTH-1]};
    diff = rem[WIDTH-1:0] - opnd;
    if (div) begin
      // partial remainder always stays below divisor
      if (rem >= {1'b0, opnd}) begin
        acc_nxt = diff;
        mq_nxt  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem[WIDTH-1:0];
        mq_nxt  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      mq_nxt  = {sum[0], mq[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide, one bit per cycle.
// MDU_FAST_SPECIAL_EN skips CALC for trivial operands.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state;
  mdu_op_e          op_q;
  logic             sa, sb, bz, ovf;
  logic [WIDTH-1:0] a_q, mb, acc, mq;
  logic [CW-1:0]    cnt;

  mdu_op_e          op_e;
  logic             sa_in, sb_in, bz_in, ovf_in, fast;
  logic [WIDTH-1:0] ma, mbv;
  logic [WIDTH-1:0] acc_nxt, mq_nxt;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_comb begin
    op_e   = mdu_op_e'(op);
    sa_in  = sgn_a(op_e) & a[WIDTH-1];
    sb_in  = sgn_b(op_e) & b[WIDTH-1];
    ma     = sa_in ? -a : a;
    mbv    = sb_in ? -b : b;
    bz_in  = (b == '0);
    ovf_in = (op_e inside {OP_DIV, OP_REM}) &&
             (a == MINV) && (b == '1);
`ifdef MDU_FAST_SPECIAL_EN
    fast = is_div(op_e) ? (bz_in | ovf_in)
                        : (bz_in | (a == '0));
`else
    fast = 1'b0;
`endif
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div     (is_div(op_q)),
    .acc     (acc),
    .mq      (mq),
    .opnd    (mb),
    .acc_nxt (acc_nxt),
    .mq_nxt  (mq_nxt)
  );

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   q_s, r_s, fix_res;
  logic               neg, rem_op;
  logic               mul_lo, mul_hi;
  logic               dv_bz, dv_ovf, dv_ok;

  always_comb begin
    neg    = sa ^ sb;
    rem_op = op_q[1];
    prod   = {acc, mq};
    prod_s = neg ? -prod : prod;
    q_s    = neg ? -mq : mq;
    r_s    = sa ? -acc : acc;
    mul_lo = (op_q == OP_MUL);
    mul_hi = !is_div(op_q) && (op_q != OP_MUL);
    dv_bz  = is_div(op_q) && bz;
    dv_ovf = is_div(op_q) && !bz && ovf;
    dv_ok  = is_div(op_q) && !bz && !ovf;
    fix_res = '0;
    unique case (1'b1)
      mul_lo: fix_res = prod_s[WIDTH-1:0];
      mul_hi: fix_res = prod_s[2*WIDTH-1:WIDTH];
      dv_bz:  fix_res = rem_op ? a_q : '1;
      dv_ovf: fix_res = rem_op ? '0 : a_q;
      dv_ok:  fix_res = rem_op ? r_s : q_s;
      default: fix_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      op_q      <= OP_MUL;
      sa        <= 1'b0;
      sb        <= 1'b0;
      bz        <= 1'b0;
      ovf       <= 1'b0;
      a_q       <= '0;
      mb        <= '0;
      acc       <= '0;
      mq        <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q  <= op_e;
          sa    <= sa_in;
          sb    <= sb_in;
          bz    <= bz_in;
          ovf   <= ovf_in;
          a_q   <= a;
          mb    <= mbv;
          acc   <= '0;
          // zero product on the fast path
          mq    <= fast ? '0 : ma;
          cnt   <= '0;
          state <= fast ? FIXUP : CALC;
        end
        CALC: begin
          acc <= acc_nxt;
          mq  <= mq_nxt;
          if (cnt == CW'(WIDTH - 1)) state <= FIXUP;
          else cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
